// File: rtl/lap_memory_reader_pkg.sv
// Shared stopwatch definitions: lap memory geometry defaults and the
// readback FSM state encoding, common to writer, reader and memory.
package lap_memory_reader_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    REQ  = S_REQ,
    CAPT = S_CAPT,
    HOLD = S_HOLD
  } state_e;

  // Number of entries to read: the stored count, limited to the memory depth
  // so the read pointer can never wrap.
  function automatic int unsigned clamp_len(input int unsigned count,
                                            input int unsigned depth);
    return (count > depth) ? depth : count;
  endfunction

endpackage

// File: rtl/lap_memory_reader_if.sv
// Bus bundle of the lap readback engine: memory read port plus the
// valid/ready output stream towards display / serial logic.
interface lap_memory_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic [DATA_W-1:0] mem_data_read;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Reader side: drives the memory read port and the output stream.
  modport master (
    output mem_addr,
    output mem_read,
    input  mem_data_read,
    output out_data,
    output out_valid,
    input  out_ready
  );

  // Memory / downstream side.
  modport slave (
    input  mem_addr,
    input  mem_read,
    output mem_data_read,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/lap_memory_reader.sv
// Lap memory readback engine: walks the lap memory from address 0 and
// presents each stored snapshot on a valid/ready stream. Read-only access.
module lap_memory_reader
  import lap_memory_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [ADDR_W:0]     entry_count_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [ADDR_W:0]     read_count_o,
  lap_memory_reader_if.master bus
);

  localparam int          LEN_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    read_count_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_read_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                done_q;

  logic [LEN_W-1:0]    len_d;
  logic [LEN_W-1:0]    read_count_d;
  logic [ADDR_W-1:0]   ptr_d;

  // Candidate values used by the FSM: clamped length, next count, next address.
  always_comb begin
    len_d        = LEN_W'(clamp_len(32'(entry_count_i), DEPTH));
    read_count_d = read_count_q + 1'b1;
    ptr_d        = ptr_q + 1'b1;
  end

  // Readback FSM with registered outputs; stop overrides everything but reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      len_q        <= '0;
      read_count_q <= '0;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop_i) begin
        state_q     <= IDLE;
        mem_read_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              len_q        <= len_d;
              ptr_q        <= '0;
              read_count_q <= '0;
              if (len_d == '0) begin
                // Empty memory: report completion without touching it.
                done_q <= 1'b1;
              end else begin
                state_q    <= REQ;
                mem_addr_q <= '0;
                mem_read_q <= 1'b1;
              end
            end
          end
          REQ: begin
            mem_read_q <= 1'b0;
            state_q    <= CAPT;
          end
          CAPT: begin
            out_data_q  <= bus.mem_data_read;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
          HOLD: begin
            if (bus.out_ready) begin
              out_valid_q  <= 1'b0;
              read_count_q <= read_count_d;
              if (read_count_d == len_q) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end else begin
                ptr_q      <= ptr_d;
                mem_addr_q <= ptr_d;
                mem_read_q <= 1'b1;
                state_q    <= REQ;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign read_count_o  = read_count_q;

endmodule

// File: tb/tb_lap_memory_reader.sv
// Directed bench for the lap memory readback engine with a behavioural
// lap store and an output scoreboard.
module tb_lap_memory_reader;
  import lap_memory_reader_pkg::*;

  localparam int DATA_W = DATA_W_DEF;
  localparam int ADDR_W = ADDR_W_DEF;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              stop_i;
  logic [ADDR_W:0]   entry_count_i;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W:0]   read_count_o;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  int vectors     = 0;
  int miscompares = 0;
  int rd_total    = 0;
  int done_total  = 0;
  logic [ADDR_W-1:0] next_addr = '0;
  logic [DATA_W-1:0] sb[$];

  int r0, d0;

  lap_memory_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  lap_memory_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .entry_count_i (entry_count_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .read_count_o  (read_count_o),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  // Lap store: write port for preload, registered read one cycle after mem_read.
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (bus.mem_read) bus.mem_data_read <= mem[bus.mem_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input int a, input int d);
    we    = 1'b1;
    waddr = ADDR_W'(a);
    wdata = DATA_W'(d);
    tick();
    we    = 1'b0;
  endtask

  // Pulse start for one cycle; returns in cycle 1 relative to the pulse.
  task automatic do_start(input int cnt);
    entry_count_i = (ADDR_W+1)'(cnt);
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done_o, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},       busy_o,        0);
    check({tag, "_done"},       done_o,        0);
    check({tag, "_read_count"}, read_count_o,  0);
    check({tag, "_mem_addr"},   bus.mem_addr,  0);
    check({tag, "_mem_read"},   bus.mem_read,  0);
    check({tag, "_out_data"},   bus.out_data,  0);
    check({tag, "_out_valid"},  bus.out_valid, 0);
  endtask

  initial begin
    rst           = 1'b1;
    start_i       = 1'b0;
    stop_i        = 1'b0;
    entry_count_i = '0;
    bus.out_ready = 1'b0;
    we            = 1'b0;
    waddr         = '0;
    wdata         = '0;

    // Monitor: address sequence, done pulses and scoreboard on each handshake.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (start_i && !stop_i && !busy_o) next_addr = '0;
          if (bus.mem_read) begin
            rd_total++;
            check("mem_addr_seq", bus.mem_addr, next_addr);
            next_addr = next_addr + 1'b1;
          end
          if (done_o) done_total++;
          if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
            else check("out_data", bus.out_data, sb.pop_front());
          end
        end
      end
    join_none

    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    write_mem(0, 8'h11);
    write_mem(1, 8'h22);
    write_mem(2, 8'h33);

    // Streaming readback with ready held high: valid at 3,6,9, done at 10.
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
    bus.out_ready = 1'b1;
    d0 = done_total;
    do_start(3);
    check("t1_mem_read_c1", bus.mem_read, 1);
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("t1_valid_c%0d", c), bus.out_valid, (c == 3 || c == 6 || c == 9));
      check($sformatf("t1_done_c%0d", c),  done_o,        (c == 10));
      check($sformatf("t1_busy_c%0d", c),  busy_o,        (c <= 9));
      if (c < 10) tick();
    end
    tick();
    check("t1_read_count", read_count_o, 3);
    check("t1_sb_left", sb.size(), 0);
    check("t1_done_once", done_total - d0, 1);

    // Backpressure: ready low for 5 cycles in the first HOLD.
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
    bus.out_ready = 1'b0;
    do_start(3);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_valid_%0d", k),    bus.out_valid, 1);
      check($sformatf("t2_data_%0d", k),     bus.out_data,  8'h11);
      check($sformatf("t2_mem_read_%0d", k), bus.mem_read,  0);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_done(40, "t2");
    tick();
    check("t2_read_count", read_count_o, 3);
    check("t2_sb_left", sb.size(), 0);

    // Empty memory: done next cycle, no reads, never busy.
    r0 = rd_total;
    d0 = done_total;
    do_start(0);
    check("t3_done_c1", done_o, 1);
    check("t3_busy_c1", busy_o, 0);
    check("t3_mem_read_c1", bus.mem_read, 0);
    tick();
    check("t3_done_c2", done_o, 0);
    check("t3_busy_c2", busy_o, 0);
    check("t3_reads", rd_total - r0, 0);
    check("t3_done_once", done_total - d0, 1);

    // Oversized entry_count: exactly the full depth is read, no wrap.
    for (int i = 0; i < DEPTH; i++) write_mem(i, i);
    for (int i = 0; i < DEPTH; i++) sb.push_back(DATA_W'(i));
    r0 = rd_total;
    d0 = done_total;
    bus.out_ready = 1'b1;
    do_start(DEPTH + 5);
    wait_done(1000, "t4");
    tick();
    tick();
    check("t4_read_count", read_count_o, DEPTH);
    check("t4_reads", rd_total - r0, DEPTH);
    check("t4_done_once", done_total - d0, 1);
    check("t4_sb_left", sb.size(), 0);
    check("t4_busy", busy_o, 0);

    // Stop during the second HOLD.
    write_mem(0, 8'h11);
    write_mem(1, 8'h22);
    write_mem(2, 8'h33);
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
    d0 = done_total;
    bus.out_ready = 1'b1;
    do_start(3);
    for (int k = 0; k < 5; k++) tick();
    check("t5_valid_hold2", bus.out_valid, 1);
    check("t5_data_hold2", bus.out_data, 8'h22);
    stop_i        = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    stop_i = 1'b0;
    check("t5_valid", bus.out_valid, 0);
    check("t5_busy", busy_o, 0);
    check("t5_done", done_o, 0);
    check("t5_mem_read", bus.mem_read, 0);
    check("t5_read_count", read_count_o, 1);
    tick();
    check("t5_done_later", done_o, 0);
    check("t5_no_done", done_total - d0, 0);
    sb.delete();
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
    bus.out_ready = 1'b1;
    do_start(3);
    check("t5_restart_addr", bus.mem_addr, 0);
    wait_done(40, "t5_restart");
    tick();
    check("t5_restart_count", read_count_o, 3);
    check("t5_restart_sb", sb.size(), 0);

    // Asynchronous reset in the middle of a readback.
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
    do_start(3);
    tick();
    tick();
    check("t6_valid_before", bus.out_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
    do_start(3);
    check("t6_restart_mem_read", bus.mem_read, 1);
    wait_done(40, "t6_restart");
    tick();
    check("t6_restart_count", read_count_o, 3);
    check("t6_restart_sb", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
